hpet_multi: RTL and testbench



---
 rtl/hpet_pkg.sv | 30 +++
 rtl/hpet_multi_if.sv | 16 +
 rtl/hpet_channel.sv | 66 ++++++
 rtl/hpet_multi.sv | 155 +++++++++++++++
 tb/tb_hpet_multi.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hpet_pkg.sv
// Shared register map and field positions for the hpet_multi event timer.
package hpet_pkg;

    localparam int unsigned OffGcfg     = 'h00;
    localparam int unsigned OffCount    = 'h04;
    localparam int unsigned OffIntSts   = 'h08;
    localparam int unsigned OffPrescale = 'h0C;

    localparam int unsigned ChBase   = 'h10;
    localparam int unsigned ChStride = 'h10;
    localparam int unsigned SubCcfg  = 'h0;
    localparam int unsigned SubCmp   = 'h4;
    localparam int unsigned SubStp   = 'h8;

    localparam int unsigned GcfgStartBit    = 0;
    localparam int unsigned CcfgIntEnBit    = 0;
    localparam int unsigned CcfgPeriodicBit = 1;
    localparam int unsigned PrescaleW       = 16;

    typedef struct packed {
        logic ccfg;
        logic cmp;
        logic stp;
    } ch_we_t;

    function automatic int unsigned ch_addr(int unsigned ch, int unsigned sub);
        return ChBase + ChStride * ch + sub;
    endfunction

endpackage

// File: rtl/hpet_multi_if.sv
// APB slave bus bundle for hpet_multi.
interface hpet_multi_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;

    modport master (output psel, output penable, output pwrite, output paddr, output pwdata,
                    input prdata);
    modport slave  (input psel, input penable, input pwrite, input paddr, input pwdata,
                    output prdata);
endinterface

// File: rtl/hpet_channel.sv
// One comparator channel: holds cmp/stp/ccfg, flags a match and reloads cmp in periodic mode.
module hpet_channel
    import hpet_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             apb_pclk,
    input  logic             apb_prstn,
    input  logic [CNT_W-1:0] count,
    input  logic             tick,
    input  logic             start,
    input  ch_we_t           we,
    input  logic [31:0]      wdata,
    output logic             match,
    output logic             int_en,
    output logic [31:0]      ccfg_rd,
    output logic [31:0]      cmp_rd,
    output logic [31:0]      stp_rd
);

    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic [CNT_W-1:0] stp_q;
    logic             int_en_q;
    logic             periodic_q;

    assign match = start & tick & (count == cmp_q);

    // A bus write to CMP overrides a coincident periodic reload.
    always_comb begin
        cmp_d = cmp_q;
        if (we.cmp) begin
            cmp_d = wdata[CNT_W-1:0];
        end else if (match && periodic_q) begin
            cmp_d = cmp_q + stp_q;
        end
    end

    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            cmp_q      <= '1;
            stp_q      <= '0;
            int_en_q   <= 1'b0;
            periodic_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
            if (we.stp) begin
                stp_q <= wdata[CNT_W-1:0];
            end
            if (we.ccfg) begin
                int_en_q   <= wdata[CcfgIntEnBit];
                periodic_q <= wdata[CcfgPeriodicBit];
            end
        end
    end

    always_comb begin
        ccfg_rd                  = '0;
        ccfg_rd[CcfgIntEnBit]    = int_en_q;
        ccfg_rd[CcfgPeriodicBit] = periodic_q;
    end

    assign int_en = int_en_q;
    assign cmp_rd = 32'(cmp_q);
    assign stp_rd = 32'(stp_q);

endmodule

// File: rtl/hpet_multi.sv
// Multi-channel event timer on APB: shared main counter, N_CH comparators, W1C status.
// Optional prescaler enabled by defining HPET_PRESCALE_EN.
module hpet_multi
    import hpet_pkg::*;
#(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned ADDR_W = 8
) (
    input  logic            apb_pclk,
    input  logic            apb_prstn,
    hpet_multi_if.slave     apb,
    output logic [N_CH-1:0] int_o,
    output logic            irq_o
);

    logic             wr_stb, rd_stb;
    logic             sel_gcfg, sel_count, sel_sts;
    logic             start_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [N_CH-1:0]  sts_q, sts_d;
    logic [N_CH-1:0]  match, ch_int_en;
    logic             tick;
    logic [31:0]      rdata;

    ch_we_t      ch_we   [N_CH];
    logic [31:0] ch_ccfg [N_CH];
    logic [31:0] ch_cmp  [N_CH];
    logic [31:0] ch_stp  [N_CH];

    assign wr_stb = apb.psel & apb.penable & apb.pwrite;
    assign rd_stb = apb.psel & apb.penable & ~apb.pwrite;

    assign sel_gcfg  = (apb.paddr == ADDR_W'(OffGcfg));
    assign sel_count = (apb.paddr == ADDR_W'(OffCount));
    assign sel_sts   = (apb.paddr == ADDR_W'(OffIntSts));

`ifdef HPET_PRESCALE_EN
    logic                 sel_prescale;
    logic [PrescaleW-1:0] prescale_q;
    logic [PrescaleW-1:0] pre_cnt_q, pre_cnt_d;

    assign sel_prescale = (apb.paddr == ADDR_W'(OffPrescale));
    assign tick         = (pre_cnt_q == prescale_q);

    // Held at 0 while stopped so a restart always waits a full PRESCALE+1 cycles.
    always_comb begin
        pre_cnt_d = pre_cnt_q + PrescaleW'(1);
        if (!start_q || (wr_stb && sel_prescale) || tick) begin
            pre_cnt_d = '0;
        end
    end

    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            prescale_q <= '0;
            pre_cnt_q  <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            if (wr_stb && sel_prescale) begin
                prescale_q <= apb.pwdata[PrescaleW-1:0];
            end
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        count_d = count_q;
        if (start_q) begin
            if (tick) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (wr_stb && sel_count) begin
            count_d = apb.pwdata[CNT_W-1:0];
        end
    end

    // A new match sets the bit even if the same bit is being cleared this cycle.
    always_comb begin
        sts_d = sts_q;
        if (wr_stb && sel_sts) begin
            sts_d = sts_q & ~apb.pwdata[N_CH-1:0];
        end
        sts_d = sts_d | match;
    end

    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            start_q <= 1'b0;
            count_q <= '0;
            sts_q   <= '0;
        end else begin
            count_q <= count_d;
            sts_q   <= sts_d;
            if (wr_stb && sel_gcfg) begin
                start_q <= apb.pwdata[GcfgStartBit];
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign ch_we[i] = '{
            ccfg: wr_stb && (apb.paddr == ADDR_W'(ch_addr(i, SubCcfg))),
            cmp:  wr_stb && (apb.paddr == ADDR_W'(ch_addr(i, SubCmp))),
            stp:  wr_stb && (apb.paddr == ADDR_W'(ch_addr(i, SubStp)))
        };

        hpet_channel #(
            .CNT_W (CNT_W)
        ) u_channel (
            .apb_pclk  (apb_pclk),
            .apb_prstn (apb_prstn),
            .count     (count_q),
            .tick      (tick),
            .start     (start_q),
            .we        (ch_we[i]),
            .wdata     (apb.pwdata),
            .match     (match[i]),
            .int_en    (ch_int_en[i]),
            .ccfg_rd   (ch_ccfg[i]),
            .cmp_rd    (ch_cmp[i]),
            .stp_rd    (ch_stp[i])
        );
    end

    always_comb begin
        rdata = '0;
        if (sel_gcfg) begin
            rdata[GcfgStartBit] = start_q;
        end
        if (sel_count) begin
            rdata = 32'(count_q);
        end
        if (sel_sts) begin
            rdata = 32'(sts_q);
        end
`ifdef HPET_PRESCALE_EN
        if (sel_prescale) begin
            rdata = 32'(prescale_q);
        end
`endif
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (apb.paddr == ADDR_W'(ch_addr(i, SubCcfg))) rdata = ch_ccfg[i];
            if (apb.paddr == ADDR_W'(ch_addr(i, SubCmp)))  rdata = ch_cmp[i];
            if (apb.paddr == ADDR_W'(ch_addr(i, SubStp)))  rdata = ch_stp[i];
        end
    end

    assign apb.prdata = rd_stb ? rdata : '0;
    assign int_o      = sts_q & ch_int_en;
    assign irq_o      = |int_o;

endmodule

// File: tb/tb_hpet_multi.sv
// Directed bench for hpet_multi: register table plus timed sequences for matches and collisions.
module tb_hpet_multi;

    localparam int unsigned N_CH   = 4;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned ADDR_W = 8;

    localparam logic [7:0] A_GCFG = 8'h00;
    localparam logic [7:0] A_CNT  = 8'h04;
    localparam logic [7:0] A_STS  = 8'h08;
    localparam logic [7:0] A_PRE  = 8'h0C;
    localparam logic [7:0] A_CF0  = 8'h10;
    localparam logic [7:0] A_CMP0 = 8'h14;
    localparam logic [7:0] A_STP0 = 8'h18;
    localparam logic [7:0] A_CF1  = 8'h20;
    localparam logic [7:0] A_CMP1 = 8'h24;
    localparam logic [7:0] A_STP1 = 8'h28;
    localparam logic [7:0] A_CF2  = 8'h30;
    localparam logic [7:0] A_CMP2 = 8'h34;

`ifdef HPET_PRESCALE_EN
    localparam logic [31:0] PRE_RB = 32'h0000_2345;
`else
    localparam logic [31:0] PRE_RB = 32'h0;
`endif

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    logic            apb_pclk  = 1'b0;
    logic            apb_prstn = 1'b0;
    logic [N_CH-1:0] int_o;
    logic            irq_o;
    int              n_tests   = 0;
    int              n_fail    = 0;
    vec_t            vecs[$];

    hpet_multi_if #(.ADDR_W(ADDR_W)) apb_bus ();

    hpet_multi #(
        .N_CH   (N_CH),
        .CNT_W  (CNT_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .apb_pclk  (apb_pclk),
        .apb_prstn (apb_prstn),
        .apb       (apb_bus),
        .int_o     (int_o),
        .irq_o     (irq_o)
    );

    always #5 apb_pclk = ~apb_pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
        @(negedge apb_pclk);
        apb_bus.psel    = 1'b1;
        apb_bus.penable = 1'b0;
        apb_bus.pwrite  = 1'b1;
        apb_bus.paddr   = addr;
        apb_bus.pwdata  = data;
        @(negedge apb_pclk);
        apb_bus.penable = 1'b1;
        @(negedge apb_pclk);
        apb_bus.psel    = 1'b0;
        apb_bus.penable = 1'b0;
        apb_bus.pwrite  = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [31:0] data);
        @(negedge apb_pclk);
        apb_bus.psel    = 1'b1;
        apb_bus.penable = 1'b0;
        apb_bus.pwrite  = 1'b0;
        apb_bus.paddr   = addr;
        @(negedge apb_pclk);
        apb_bus.penable = 1'b1;
        #1 data = apb_bus.prdata;
        @(negedge apb_pclk);
        apb_bus.psel    = 1'b0;
        apb_bus.penable = 1'b0;
    endtask

    task automatic check_rd(input string name, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(addr, d);
        check(name, d, exp);
    endtask

    task automatic check_int(input string name, input logic [N_CH-1:0] exp);
        check(name, 32'(int_o), 32'(exp));
    endtask

    task automatic do_reset();
        apb_prstn = 1'b0;
        repeat (2) @(negedge apb_pclk);
        apb_prstn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        apb_bus.psel    = 1'b0;
        apb_bus.penable = 1'b0;
        apb_bus.pwrite  = 1'b0;
        apb_bus.paddr   = '0;
        apb_bus.pwdata  = '0;

        vecs.push_back('{0, A_GCFG, 32'h0, 32'h0});
        vecs.push_back('{0, A_CNT,  32'h0, 32'h0});
        vecs.push_back('{0, A_STS,  32'h0, 32'h0});
        vecs.push_back('{0, A_PRE,  32'h0, 32'h0});
        for (int i = 0; i < 4; i++) begin
            vecs.push_back('{0, 8'(8'h10 + 8'h10 * i), 32'h0, 32'h0});
            vecs.push_back('{0, 8'(8'h14 + 8'h10 * i), 32'h0, 32'hFFFF_FFFF});
            vecs.push_back('{0, 8'(8'h18 + 8'h10 * i), 32'h0, 32'h0});
        end
        vecs.push_back('{1, A_CMP0, 32'h1234_5678, 32'h0});
        vecs.push_back('{0, A_CMP0, 32'h0, 32'h1234_5678});
        vecs.push_back('{1, A_CF1,  32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{0, A_CF1,  32'h0, 32'h3});
        vecs.push_back('{1, 8'h48,  32'h0000_BEEF, 32'h0});
        vecs.push_back('{0, 8'h48,  32'h0, 32'h0000_BEEF});
        vecs.push_back('{1, A_CNT,  32'hDEAD_BEEF, 32'h0});
        vecs.push_back('{0, A_CNT,  32'h0, 32'hDEAD_BEEF});
        vecs.push_back('{1, 8'h50,  32'h1, 32'h0});
        vecs.push_back('{0, 8'h50,  32'h0, 32'h0});
        vecs.push_back('{1, 8'h1C,  32'h5, 32'h0});
        vecs.push_back('{0, 8'h1C,  32'h0, 32'h0});
        vecs.push_back('{1, A_PRE,  32'h0001_2345, 32'h0});
        vecs.push_back('{0, A_PRE,  32'h0, PRE_RB});
        vecs.push_back('{1, A_GCFG, 32'hFFFF_FFFE, 32'h0});
        vecs.push_back('{0, A_GCFG, 32'h0, 32'h0});
        vecs.push_back('{1, A_STS,  32'hF, 32'h0});
        vecs.push_back('{0, A_STS,  32'h0, 32'h0});

        // Reset state
        repeat (2) @(negedge apb_pclk);
        check_int("rst_int", '0);
        check("rst_irq", 32'(irq_o), 32'h0);
        apb_prstn = 1'b1;
        @(negedge apb_pclk);
        check("idle_prdata", apb_bus.prdata, 32'h0);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].data);
            end else begin
                apb_read(vecs[i].addr, d);
                check($sformatf("vec%0d@%02h", i, vecs[i].addr), d, vecs[i].exp);
            end
        end
        check_int("table_int", '0);

        // One-shot: start effective at edge E, task returns mid-cycle after E
        do_reset();
        apb_write(A_CMP0, 32'd10);
        apb_write(A_CF0, 32'h1);
        apb_write(A_GCFG, 32'h1);
        repeat (10) @(negedge apb_pclk);
        check_int("oneshot_match_cycle", '0);
        @(negedge apb_pclk);
        check_int("oneshot_fire", 4'b0001);
        check("oneshot_irq", 32'(irq_o), 32'h1);
        apb_write(A_STS, 32'h1);
        check_int("oneshot_w1c", '0);
        check("oneshot_w1c_irq", 32'(irq_o), 32'h0);
        repeat (40) @(negedge apb_pclk);
        check_int("oneshot_no_refire", '0);
        check_rd("oneshot_cmp_kept", A_CMP0, 32'd10);

        // Periodic ch1 (5 + 7k) alongside one-shot ch2 at 5
        do_reset();
        apb_write(A_CMP1, 32'd5);
        apb_write(A_STP1, 32'd7);
        apb_write(A_CF1, 32'h3);
        apb_write(A_CMP2, 32'd5);
        apb_write(A_CF2, 32'h1);
        apb_write(A_GCFG, 32'h1);
        repeat (5) @(negedge apb_pclk);
        check_int("per_pre5", '0);
        @(negedge apb_pclk);
        check_int("per_fire5", 4'b0110);
        check_rd("per_cmp_reload", A_CMP1, 32'd12);
        apb_write(A_STS, 32'h6);
        check_int("per_clr", '0);
        @(negedge apb_pclk);
        check_int("per_fire12", 4'b0010);
        apb_write(A_STS, 32'h2);
        check_int("per_clr2", '0);
        repeat (3) @(negedge apb_pclk);
        check_int("per_pre19", '0);
        @(negedge apb_pclk);
        check_int("per_fire19", 4'b0010);
        check_rd("per_ch2_noreload", A_CMP2, 32'd5);

        // Wrap: count FFFFFFFE -> FFFFFFFF -> 0 -> 1, one-shot match on 1
        do_reset();
        apb_write(A_CNT, 32'hFFFF_FFFE);
        apb_write(A_CMP0, 32'd1);
        apb_write(A_CF0, 32'h1);
        apb_write(A_GCFG, 32'h1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge apb_pclk);
            check_int($sformatf("wrap_pre%0d", k), '0);
        end
        @(negedge apb_pclk);
        check_int("wrap_fire", 4'b0001);

        // Periodic reload across the wrap: FFFFFFFF + 3 = 2; stopped right after
        do_reset();
        apb_write(A_CNT, 32'hFFFF_FFFE);
        apb_write(A_CMP1, 32'hFFFF_FFFF);
        apb_write(A_STP1, 32'd3);
        apb_write(A_CF1, 32'h3);
        apb_write(A_GCFG, 32'h1);
        apb_write(A_GCFG, 32'h0);
        check_rd("wrap_reload_cmp", A_CMP1, 32'd2);
        check_rd("wrap_held_count", A_CNT, 32'd1);
        check_int("wrap_reload_int", 4'b0010);

        // W1C landing on the match edge: set wins
        do_reset();
        apb_write(A_CMP0, 32'd2);
        apb_write(A_CF0, 32'h1);
        apb_write(A_GCFG, 32'h1);
        apb_write(A_STS, 32'h1);
        check_int("w1c_vs_set", 4'b0001);
        apb_write(A_STS, 32'h1);
        check_int("w1c_after", '0);

        // CMP write on the reload edge: written value wins
        do_reset();
        apb_write(A_CMP0, 32'd2);
        apb_write(A_STP0, 32'd100);
        apb_write(A_CF0, 32'h3);
        apb_write(A_GCFG, 32'h1);
        apb_write(A_CMP0, 32'd50);
        check_rd("cmp_vs_reload", A_CMP0, 32'd50);
        check_int("cmp_vs_reload_int", 4'b0001);

        // STP write on the reload edge: reload uses old step
        do_reset();
        apb_write(A_CMP1, 32'd2);
        apb_write(A_STP1, 32'd100);
        apb_write(A_CF1, 32'h2);
        apb_write(A_GCFG, 32'h1);
        apb_write(A_STP1, 32'd7);
        check_rd("stp_vs_reload_cmp", A_CMP1, 32'd102);
        check_rd("stp_vs_reload_stp", A_STP1, 32'd7);

        // COUNT write while running is ignored; 6 increments before the stop edge
        do_reset();
        apb_write(A_GCFG, 32'h1);
        apb_write(A_CNT, 32'd1000);
        apb_write(A_GCFG, 32'h0);
        check_rd("count_wr_running", A_CNT, 32'd6);

        // Reset asserted in the match cycle
        do_reset();
        apb_write(A_CMP0, 32'd3);
        apb_write(A_CF0, 32'h1);
        apb_write(A_GCFG, 32'h1);
        repeat (3) @(negedge apb_pclk);
        apb_prstn = 1'b0;
        @(negedge apb_pclk);
        check_int("midrst_int", '0);
        check("midrst_irq", 32'(irq_o), 32'h0);
        apb_prstn = 1'b1;
        check_rd("midrst_count", A_CNT, 32'h0);
        check_rd("midrst_gcfg", A_GCFG, 32'h0);
        check_rd("midrst_cmp", A_CMP0, 32'hFFFF_FFFF);
        check_rd("midrst_sts", A_STS, 32'h0);
        check_int("midrst_int_after", '0);

`ifdef HPET_PRESCALE_EN
        // PRESCALE=3: increments at E+4, E+8, E+12; stop lands at E+13
        do_reset();
        apb_write(A_PRE, 32'd3);
        apb_write(A_GCFG, 32'h1);
        repeat (10) @(negedge apb_pclk);
        apb_write(A_GCFG, 32'h0);
        check_rd("pre_count3", A_CNT, 32'd3);
        apb_write(A_GCFG, 32'h1);
        apb_write(A_GCFG, 32'h0);
        check_rd("pre_short_run", A_CNT, 32'd3);
        apb_write(A_GCFG, 32'h1);
        @(negedge apb_pclk);
        apb_write(A_GCFG, 32'h0);
        check_rd("pre_full_first_tick", A_CNT, 32'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
